// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: latches ALU {z,n,v} flags and resolves conditional, optionally linking, branches.
// Optional BRANCH_STATS_EN adds saturating resolved/taken counters (stat_resolved, stat_taken).
//
// state    | meaning
// IDLE     | ready for a request, br_ready=1
// EVAL     | condition evaluated from flags_q; not taken resolves here
// LINK     | one-cycle register-file write of pc4 to LINK_REG
// REDIRECT | pc_sel pulse with latched target, taken resolution
module branch_resolve_unit #(
    parameter int DATA_W   = 32,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_we,
    input  logic              zin,
    input  logic              nin,
    input  logic              vin,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic              br_link,
    input  logic [DATA_W-1:0] pc4,
    input  logic [DATA_W-1:0] br_target,
    output logic [2:0]        flags_q,
    output logic              link_we,
    output logic [4:0]        link_addr,
    output logic [DATA_W-1:0] link_data,
    output logic              pc_sel,
    output logic [DATA_W-1:0] pc_target,
    output logic              br_done,
    output logic              br_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_resolved,
    output logic [CNT_W-1:0]  stat_taken
`endif
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EVAL     = 2'd1;
    localparam logic [1:0] LINK     = 2'd2;
    localparam logic [1:0] REDIRECT = 2'd3;

    localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

    if (CNT_W < 1 || DATA_W < 1) begin : g_bad_params
        $error("branch_resolve_unit: CNT_W and DATA_W must be at least 1");
    end

    logic [1:0]        state_q, state_d;
    logic [2:0]        flags_d;
    logic [2:0]        cond_q, cond_d;
    logic              link_q, link_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              cond_met;

    // flags_q is {z, n, v}
    always_comb begin
        cond_met = 1'b0;
        case (cond_q)
            3'b000:  cond_met = 1'b0;
            3'b001:  cond_met = 1'b1;
            3'b010:  cond_met = flags_q[2];
            3'b011:  cond_met = !flags_q[2];
            3'b100:  cond_met = flags_q[1];
            3'b101:  cond_met = !flags_q[1] && !flags_q[2];
            3'b110:  cond_met = flags_q[0];
            3'b111:  cond_met = flags_q[1] || flags_q[2];
            default: cond_met = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cond_d   = cond_q;
        link_d   = link_q;
        pc4_d    = pc4_q;
        target_d = target_q;
        flags_d  = flag_we ? {zin, nin, vin} : flags_q;
        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    cond_d   = br_cond;
                    link_d   = br_link;
                    pc4_d    = pc4;
                    target_d = br_target;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                if (!cond_met) begin
                    state_d = IDLE;
                end else if (link_q) begin
                    state_d = LINK;
                end else begin
                    state_d = REDIRECT;
                end
            end
            LINK:     state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            flags_q  <= 3'b000;
            cond_q   <= 3'b000;
            link_q   <= 1'b0;
            pc4_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            cond_q   <= cond_d;
            link_q   <= link_d;
            pc4_q    <= pc4_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        br_ready  = (state_q == IDLE);
        link_we   = 1'b0;
        link_addr = 5'd0;
        link_data = '0;
        pc_sel    = 1'b0;
        pc_target = '0;
        br_done   = 1'b0;
        br_taken  = 1'b0;
        case (state_q)
            EVAL: begin
                br_done = !cond_met;
            end
            LINK: begin
                link_we   = 1'b1;
                link_addr = LINK_ADDR;
                link_data = pc4_q;
            end
            REDIRECT: begin
                pc_sel    = 1'b1;
                pc_target = target_q;
                br_done   = 1'b1;
                br_taken  = 1'b1;
            end
            default: begin
                br_done = 1'b0;
            end
        endcase
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stat_resolved_q, stat_resolved_d;
    logic [CNT_W-1:0] stat_taken_q, stat_taken_d;

    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_taken_d    = stat_taken_q;
        if (br_done && (stat_resolved_q != {CNT_W{1'b1}})) begin
            stat_resolved_d = stat_resolved_q + 1'b1;
        end
        if (br_done && br_taken && (stat_taken_q != {CNT_W{1'b1}})) begin
            stat_taken_d = stat_taken_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_resolved_q <= '0;
            stat_taken_q    <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_taken_q    <= stat_taken_d;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized requests
// checked against a cycle-level behavioural model of the request/resolve protocol.
module tb_branch_resolve_unit;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flag_we = 1'b0;
    logic              zin = 1'b0;
    logic              nin = 1'b0;
    logic              vin = 1'b0;
    logic              br_valid = 1'b0;
    logic              br_ready;
    logic [2:0]        br_cond = 3'b000;
    logic              br_link = 1'b0;
    logic [DATA_W-1:0] pc4 = '0;
    logic [DATA_W-1:0] br_target = '0;
    logic [2:0]        flags_q;
    logic              link_we;
    logic [4:0]        link_addr;
    logic [DATA_W-1:0] link_data;
    logic              pc_sel;
    logic [DATA_W-1:0] pc_target;
    logic              br_done;
    logic              br_taken;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0]  stat_resolved;
    logic [CNT_W-1:0]  stat_taken;
`endif

    branch_resolve_unit #(.DATA_W(DATA_W), .LINK_REG(31), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flag_we(flag_we), .zin(zin), .nin(nin), .vin(vin),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_link(br_link),
        .pc4(pc4), .br_target(br_target), .flags_q(flags_q), .link_we(link_we),
        .link_addr(link_addr), .link_data(link_data), .pc_sel(pc_sel), .pc_target(pc_target),
        .br_done(br_done), .br_taken(br_taken)
`ifdef BRANCH_STATS_EN
        , .stat_resolved(stat_resolved), .stat_taken(stat_taken)
`endif
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [2:0] m_flags = 3'b000;
    int unsigned m_resolved = 0;
    int unsigned m_taken = 0;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    // Condition table, written directly from the condition-code definitions.
    function automatic logic exp_taken(input logic [2:0] c, input logic [2:0] f);
        logic z, n, v;
        z = f[2]; n = f[1]; v = f[0];
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return z;
            3'd3: return !z;
            3'd4: return n;
            3'd5: return !n && !z;
            3'd6: return v;
            default: return n || z;
        endcase
    endfunction

    function automatic int unsigned sat_inc(input int unsigned x);
        return (x >= CNT_MAX) ? CNT_MAX : x + 1;
    endfunction

    task automatic run_branch(input logic [2:0] cond, input logic link,
                              input logic [DATA_W-1:0] p4, input logic [DATA_W-1:0] tgt,
                              input logic fw_acc, input logic [2:0] fl_acc,
                              input logic fw_eval, input logic [2:0] fl_eval,
                              input string name);
        logic tk;
        @(negedge clk);
        vec_cnt++;
        if (br_ready !== 1'b1 || br_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s idle: ready=%b done=%b, want ready=1 done=0", name, br_ready, br_done);
        end
`ifdef BRANCH_STATS_EN
        vec_cnt++;
        if (stat_resolved !== CNT_W'(m_resolved) || stat_taken !== CNT_W'(m_taken)) begin
            err_cnt++;
            $display("FAIL %s stats: got %0d/%0d want %0d/%0d", name, stat_resolved, stat_taken,
                     m_resolved, m_taken);
        end
`endif
        br_valid = 1'b1; br_cond = cond; br_link = link; pc4 = p4; br_target = tgt;
        flag_we = fw_acc; {zin, nin, vin} = fl_acc;
        @(posedge clk);
        if (fw_acc) m_flags = fl_acc;
        tk = exp_taken(cond, m_flags);
        @(negedge clk);
        br_valid = 1'b0; br_cond = 3'($urandom); br_link = 1'($urandom);
        pc4 = $urandom; br_target = $urandom;
        flag_we = fw_eval; {zin, nin, vin} = fl_eval;
        vec_cnt++;
        if ({br_done, br_taken, pc_sel, link_we, br_ready} !== {!tk, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL %s eval: done/taken/sel/we/rdy=%b%b%b%b%b want %b0000", name,
                     br_done, br_taken, pc_sel, link_we, br_ready, !tk);
        end
        @(posedge clk);
        if (fw_eval) m_flags = fl_eval;
        m_resolved = sat_inc(m_resolved);
        if (tk) m_taken = sat_inc(m_taken);
        @(negedge clk);
        flag_we = 1'b0;
        if (tk && link) begin
            vec_cnt++;
            if ({link_we, link_addr, link_data, pc_sel, br_done} !== {1'b1, 5'd31, p4, 1'b0, 1'b0}) begin
                err_cnt++;
                $display("FAIL %s link: we=%b addr=%0d data=%h sel=%b done=%b want 1 31 %h 0 0", name,
                         link_we, link_addr, link_data, pc_sel, br_done, p4);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (tk) begin
            if ({pc_sel, pc_target, br_done, br_taken, link_we, link_data} !==
                {1'b1, tgt, 1'b1, 1'b1, 1'b0, {DATA_W{1'b0}}}) begin
                err_cnt++;
                $display("FAIL %s redirect: sel=%b target=%h done=%b taken=%b we=%b want 1 %h 1 1 0",
                         name, pc_sel, pc_target, br_done, br_taken, link_we, tgt);
            end
        end else begin
            if ({pc_sel, link_we, br_done, br_ready} !== 4'b0001) begin
                err_cnt++;
                $display("FAIL %s post-nt: sel/we/done/rdy=%b%b%b%b want 0001", name,
                         pc_sel, link_we, br_done, br_ready);
            end
        end
        vec_cnt++;
        if (flags_q !== m_flags) begin
            err_cnt++;
            $display("FAIL %s flags: got %b want %b", name, flags_q, m_flags);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({br_ready, flags_q, link_we, link_addr, link_data, pc_sel, pc_target, br_done, br_taken} !==
            {1'b1, 3'b000, 1'b0, 5'd0, {DATA_W{1'b0}}, 1'b0, {DATA_W{1'b0}}, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset: ready=%b flags=%b we=%b sel=%b done=%b taken=%b want 1 000 0 0 0 0",
                     br_ready, flags_q, link_we, pc_sel, br_done, br_taken);
        end
        reset = 1'b0;
        m_flags = 3'b000; m_resolved = 0; m_taken = 0;
    endtask

    task automatic test_taken_no_link();
        @(negedge clk);
        flag_we = 1'b1; {zin, nin, vin} = 3'b100;
        @(negedge clk);
        flag_we = 1'b0;
        m_flags = 3'b100;
        run_branch(3'b010, 1'b0, 32'h0040_0004, 32'h0040_0100, 1'b0, 3'b000, 1'b0, 3'b000, "taken_nolink");
    endtask

    task automatic test_taken_link();
        run_branch(3'b010, 1'b1, 32'h0040_0008, 32'h0040_0200, 1'b0, 3'b000, 1'b0, 3'b000, "taken_link");
    endtask

    task automatic test_not_taken();
        run_branch(3'b111, 1'b1, 32'h0000_1234, 32'h0000_5678, 1'b1, 3'b000, 1'b0, 3'b000, "not_taken");
        run_branch(3'b000, 1'b0, 32'h1, 32'h2, 1'b1, 3'b111, 1'b0, 3'b000, "never");
        run_branch(3'b101, 1'b0, 32'h3, 32'h4, 1'b1, 3'b000, 1'b0, 3'b000, "gt_taken");
    endtask

    task automatic test_flag_in_eval();
        run_branch(3'b010, 1'b0, 32'h10, 32'h0040_0300, 1'b1, 3'b100, 1'b1, 3'b000, "flag_in_eval");
        run_branch(3'b010, 1'b0, 32'h14, 32'h0040_0400, 1'b0, 3'b000, 1'b0, 3'b000, "after_eval_flag");
    endtask

    task automatic test_reset_in_link();
        @(negedge clk);
        br_valid = 1'b1; br_cond = 3'b001; br_link = 1'b1; pc4 = 32'hAAAA_0004; br_target = 32'hBBBB_0000;
        flag_we = 1'b1; {zin, nin, vin} = 3'b011;
        @(negedge clk);
        br_valid = 1'b0; flag_we = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (link_we !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_link pre: link_we=%b want 1", link_we);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_flags = 3'b000; m_resolved = 0; m_taken = 0;
        vec_cnt++;
        if ({pc_sel, br_done, link_we, br_ready, flags_q} !== {4'b0001, 3'b000}) begin
            err_cnt++;
            $display("FAIL rst_link post: sel/done/we/rdy=%b%b%b%b flags=%b want 0001 000",
                     pc_sel, br_done, link_we, br_ready, flags_q);
        end
        repeat (3) begin
            @(negedge clk);
            vec_cnt++;
            if (pc_sel !== 1'b0 || link_we !== 1'b0) begin
                err_cnt++;
                $display("FAIL rst_link late: sel=%b we=%b want 0 0", pc_sel, link_we);
            end
        end
    endtask

    task automatic test_back_to_back_busy();
        @(negedge clk);
        br_valid = 1'b1; br_cond = 3'b001; br_link = 1'b0; pc4 = 32'h100; br_target = 32'hA000_0000;
        @(negedge clk);
        br_cond = 3'b001; br_link = 1'b1; pc4 = 32'hB000_0004; br_target = 32'hB000_0000;
        vec_cnt++;
        if ({br_ready, br_done} !== 2'b00) begin
            err_cnt++;
            $display("FAIL busy eval: rdy=%b done=%b want 0 0", br_ready, br_done);
        end
        @(negedge clk);
        vec_cnt++;
        if ({br_ready, pc_sel, pc_target} !== {1'b0, 1'b1, 32'hA000_0000}) begin
            err_cnt++;
            $display("FAIL busy redirA: rdy=%b sel=%b target=%h want 0 1 a0000000", br_ready, pc_sel, pc_target);
        end
        @(negedge clk);
        m_resolved = sat_inc(m_resolved); m_taken = sat_inc(m_taken);
        vec_cnt++;
        if ({br_ready, br_done, pc_sel} !== 3'b100) begin
            err_cnt++;
            $display("FAIL busy idle: rdy=%b done=%b sel=%b want 1 0 0", br_ready, br_done, pc_sel);
        end
        @(negedge clk);
        br_valid = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({link_we, link_data} !== {1'b1, 32'hB000_0004}) begin
            err_cnt++;
            $display("FAIL busy linkB: we=%b data=%h want 1 b0000004", link_we, link_data);
        end
        @(negedge clk);
        vec_cnt++;
        if ({pc_sel, pc_target, br_done} !== {1'b1, 32'hB000_0000, 1'b1}) begin
            err_cnt++;
            $display("FAIL busy redirB: sel=%b target=%h done=%b want 1 b0000000 1", pc_sel, pc_target, br_done);
        end
        m_resolved = sat_inc(m_resolved); m_taken = sat_inc(m_taken);
        @(negedge clk);
        vec_cnt++;
        if ({br_ready, br_done} !== 2'b10) begin
            err_cnt++;
            $display("FAIL busy end: rdy=%b done=%b want 1 0", br_ready, br_done);
        end
`ifdef BRANCH_STATS_EN
        vec_cnt++;
        if (stat_resolved !== CNT_W'(m_resolved) || stat_taken !== CNT_W'(m_taken)) begin
            err_cnt++;
            $display("FAIL busy stats: got %0d/%0d want %0d/%0d", stat_resolved, stat_taken, m_resolved, m_taken);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            run_branch(3'($urandom), 1'($urandom), $urandom, $urandom,
                       1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), "random");
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_taken_no_link();
        test_taken_link();
        test_not_taken();
        test_flag_in_eval();
        test_reset_in_link();
        test_back_to_back_busy();
        test_random();
        run_branch(3'b001, 1'b0, 32'h0, 32'h8, 1'b0, 3'b000, 1'b0, 3'b000, "final");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
